// File: rtl/solver_pkg.sv
// Types and helpers shared by the solver pipeline blocks.
package solver_pkg;

    typedef enum logic [0:0] {
        MW_STATE__COLLECT,
        MW_STATE__EMIT
    } mw_state_t;

    // Bits needed to hold a popcount of n bits (0..n inclusive).
    function automatic int weight_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-Stream bundle used between solver pipeline stages.
interface axi_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/popcount.sv
// Combinational population count of an N-bit vector.
module popcount #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic [N-1:0] data_i,
    output logic [W-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < N; i++) begin
            count_o = count_o + W'(data_i[i]);
        end
    end

endmodule

// File: rtl/min_weight_accumulator.sv
// Per-packet minimum Hamming weight of candidate solutions, with a running
// total of minima, a packet counter and a sticky wrap flag.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  COLLECT | accepting solution beats, tracking the smallest weight
//  EMIT    | presenting result_min, waiting for result_ready
module min_weight_accumulator
    import solver_pkg::*;
#(
    parameter int VARS_COUNT = 7,
    parameter int DATA_WIDTH = 8,
    parameter int TOTAL_W    = 32,
    localparam int WW        = weight_width(VARS_COUNT)
) (
    input  logic               clk,
    input  logic               rst,
    axi_stream_if.slave        solution_stream,
    input  logic               clear,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [WW-1:0]      result_min,
    output logic [TOTAL_W-1:0] total,
    output logic [TOTAL_W-1:0] packet_count,
    output logic               overflow
);

    localparam int SW = TOTAL_W + 1;

    mw_state_t state_q, state_d;

    logic                  first_q;
    logic [WW-1:0]         best_q;
    logic [WW-1:0]         rmin_q;
    logic [TOTAL_W-1:0]    total_q, total_d;
    logic [TOTAL_W-1:0]    count_q, count_d;
    logic                  ovf_q, ovf_d;

    logic [DATA_WIDTH-1:0] tdata_w;
    logic [WW-1:0]         w;
    logic [WW-1:0]         cand;
    logic                  tready_int;
    logic                  beat;
    logic                  hs;
    logic [TOTAL_W-1:0]    base_total;
    logic [TOTAL_W-1:0]    base_count;
    logic [SW-1:0]         sum;
    logic                  unused_tdata_hi;

    // Bits above VARS_COUNT carry no solution information and are dropped.
    assign tdata_w         = solution_stream.tdata;
    assign unused_tdata_hi = ^tdata_w;

    popcount #(
        .N (VARS_COUNT),
        .W (WW)
    ) u_popcount (
        .data_i  (tdata_w[VARS_COUNT-1:0]),
        .count_o (w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= MW_STATE__COLLECT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MW_STATE__COLLECT: if (beat && solution_stream.tlast) state_d = MW_STATE__EMIT;
            MW_STATE__EMIT:    if (result_ready)                  state_d = MW_STATE__COLLECT;
            default:           state_d = MW_STATE__COLLECT;
        endcase
    end

    always_comb begin
        tready_int   = (state_q == MW_STATE__COLLECT);
        result_valid = (state_q == MW_STATE__EMIT);
    end

    assign solution_stream.tready = tready_int;
    assign beat = solution_stream.tvalid & tready_int;
    assign hs   = result_valid & result_ready;
    assign cand = (first_q || (w < best_q)) ? w : best_q;

    // clear takes effect before a same-cycle handshake adds its result.
    always_comb begin
        base_total = clear ? '0 : total_q;
        base_count = clear ? '0 : count_q;
        sum        = {1'b0, base_total} + SW'(rmin_q);
        total_d    = hs ? sum[TOTAL_W-1:0] : base_total;
        count_d    = hs ? base_count + TOTAL_W'(1) : base_count;
        ovf_d      = (clear ? 1'b0 : ovf_q) | (hs & sum[TOTAL_W]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q <= 1'b1;
            best_q  <= '0;
            rmin_q  <= '0;
            total_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (beat) begin
                if (solution_stream.tlast) begin
                    rmin_q  <= cand;
                    first_q <= 1'b1;
                end else begin
                    best_q  <= cand;
                    first_q <= 1'b0;
                end
            end
            total_q <= total_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign result_min   = rmin_q;
    assign total        = total_q;
    assign packet_count = count_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_min_weight_accumulator.sv
// Scoreboard bench: default-sized instance A plus a narrow-total instance B.
module tb_min_weight_accumulator;

    typedef struct {
        int min;
        int tot;
        int cnt;
        int ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    exp_t qA[$];
    exp_t qB[$];

    axi_stream_if #(.DATA_WIDTH(8))  sA ();
    axi_stream_if #(.DATA_WIDTH(16)) sB ();

    logic        clrA = 1'b0, rrA = 1'b1, validA, ovfA;
    logic [2:0]  minA;
    logic [31:0] totA, cntA;

    logic        clrB = 1'b0, rrB = 1'b1, validB, ovfB;
    logic [3:0]  minB, totB, cntB;

    min_weight_accumulator #(.VARS_COUNT(7), .DATA_WIDTH(8), .TOTAL_W(32)) dutA (
        .clk(clk), .rst(rst), .solution_stream(sA), .clear(clrA),
        .result_valid(validA), .result_ready(rrA), .result_min(minA),
        .total(totA), .packet_count(cntA), .overflow(ovfA)
    );

    min_weight_accumulator #(.VARS_COUNT(12), .DATA_WIDTH(16), .TOTAL_W(4)) dutB (
        .clk(clk), .rst(rst), .solution_stream(sB), .clear(clrB),
        .result_valid(validB), .result_ready(rrB), .result_min(minB),
        .total(totB), .packet_count(cntB), .overflow(ovfB)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int m, input int t, input int c, input int o);
        exp_t e;
        e.min = m; e.tot = t; e.cnt = c; e.ovf = o;
        return e;
    endfunction

    // Present one beat and hold it until the DUT takes it (bounded wait).
    task automatic send(input bit sel, input logic [15:0] d, input bit last);
        bit acc = 1'b0;
        if (!sel) begin sA.tvalid = 1'b1; sA.tdata = d[7:0]; sA.tlast = last; end
        else      begin sB.tvalid = 1'b1; sB.tdata = d;      sB.tlast = last; end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sel ? sB.tready : sA.tready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) chk("beat_accept_timeout", 0, 1);
        else begin
            @(posedge clk);
            #1;
        end
        if (!sel) sA.tvalid = 1'b0; else sB.tvalid = 1'b0;
    endtask

    task automatic drain(input bit sel);
        bit done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if ((sel ? qB.size() : qA.size()) == 0 && !(sel ? validB : validA)) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk(sel ? "drain_B_timeout" : "drain_A_timeout", 0, 1);
    endtask

    initial begin : mon_a
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && validA && rrA) begin
                if (qA.size() == 0) chk("A_unexpected_result", 1, 0);
                else begin
                    e = qA.pop_front();
                    chk("A_result_min", minA, e.min);
                    @(posedge clk);
                    #1;
                    chk("A_total", totA, e.tot);
                    chk("A_packet_count", cntA, e.cnt);
                    chk("A_overflow", ovfA, e.ovf);
                end
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && validB && rrB) begin
                if (qB.size() == 0) chk("B_unexpected_result", 1, 0);
                else begin
                    e = qB.pop_front();
                    chk("B_result_min", minB, e.min);
                    @(posedge clk);
                    #1;
                    chk("B_total", totB, e.tot);
                    chk("B_packet_count", cntB, e.cnt);
                    chk("B_overflow", ovfB, e.ovf);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        sA.tvalid = 1'b0; sA.tdata = '0; sA.tlast = 1'b0;
        sB.tvalid = 1'b0; sB.tdata = '0; sB.tlast = 1'b0;
        #3;
        chk("rst_result_valid", validA, 0);
        chk("rst_result_min", minA, 0);
        chk("rst_total", totA, 0);
        chk("rst_packet_count", cntA, 0);
        chk("rst_overflow", ovfA, 0);
        chk("rst_tready", sA.tready, 1);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // min(3,1,2)=1, visible one cycle after the last beat
        qA.push_back(mk(1, 1, 1, 0));
        send(0, 16'h07, 0);
        send(0, 16'h01, 0);
        send(0, 16'h0C, 1);
        chk("latency_valid", validA, 1);
        chk("latency_min", minA, 1);

        qA.push_back(mk(0, 1, 2, 0));
        send(0, 16'h00, 1);
        qA.push_back(mk(2, 3, 3, 0));
        send(0, 16'h7F, 0);
        send(0, 16'h03, 1);
        drain(0);

        // consumer stall while upstream already offers the next packet
        rrA = 1'b0;
        qA.push_back(mk(1, 4, 4, 0));
        send(0, 16'h10, 1);
        sA.tvalid = 1'b1; sA.tdata = 8'h3F; sA.tlast = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_tready", sA.tready, 0);
            chk("stall_valid", validA, 1);
            chk("stall_min", minA, 1);
        end
        @(posedge clk); #1;
        rrA = 1'b1;
        qA.push_back(mk(6, 10, 5, 0));
        send(0, 16'h3F, 1);

        qA.push_back(mk(0, 10, 6, 0));
        send(0, 16'h80, 1);
        drain(0);

        // instance B: 4-bit total wraps on 9+9
        qB.push_back(mk(9, 9, 1, 0));
        send(1, 16'h01FF, 1);
        qB.push_back(mk(9, 2, 2, 1));
        send(1, 16'h01FF, 1);
        drain(1);
        chk("B_wrap_total", totB, 2);
        chk("B_wrap_overflow", ovfB, 1);
        clrB = 1'b1;
        @(posedge clk); #1;
        clrB = 1'b0;
        chk("B_clear_total", totB, 0);
        chk("B_clear_count", cntB, 0);
        chk("B_clear_overflow", ovfB, 0);

        rrB = 1'b0;
        qB.push_back(mk(3, 3, 1, 0));
        send(1, 16'h0007, 1);
        chk("B_hold_valid", validB, 1);
        clrB = 1'b1;
        rrB  = 1'b1;
        @(posedge clk); #1;
        clrB = 1'b0;
        drain(1);

        // async reset in the middle of a packet
        send(0, 16'h01, 0);
        send(0, 16'h00, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_total", totA, 0);
        chk("async_rst_count", cntA, 0);
        chk("async_rst_valid", validA, 0);
        chk("async_rst_min", minA, 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        qA.push_back(mk(2, 2, 1, 0));
        send(0, 16'h03, 1);
        drain(0);
        drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
